vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Downstream output stage of the snake display path: generates 640x480@60 VGA timing from the 100 MHz system clock and drives the board VGA pins.
- The game/render logic receives the current pixel coordinates and returns a 12-bit colour. This block blanks that colour outside the active area and registers it together with Hsync and Vsync.
- Uses an internal pixel clock-enable, so no separate divided clock is required.
- frame_tick gives the game logic a per-frame update strobe in the system clock domain.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz); legal range >= 1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- rgb_in  input  12  colour for (pix_x, pix_y), {R[11:8], G[7:4], B[3:0]}
- pix_x  output  10  current horizontal count, 0..H_TOTAL-1
- pix_y  output  10  current vertical count, 0..V_TOTAL-1
- pix_active  output  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE
- pix_ce  output  1  one-clk pulse every CLK_DIV clocks
- frame_tick  output  1  one-clk pulse at the start of vertical blanking
- vgaRed  output  4  registered red
- vgaGreen  output  4  registered green
- vgaBlue  output  4  registered blue
- Hsync  output  1  registered horizontal sync
- Vsync  output  1  registered vertical sync

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800; V_TOTAL = 525.
- Clock and reset: single clock clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - Divider counter = 0, h_cnt = 0, v_cnt = 0.
  - pix_ce = 0, frame_tick = 0.
  - vgaRed, vgaGreen, vgaBlue = 0.
  - Hsync and Vsync at the deasserted level (~SYNC_POL).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_ce = (div_cnt == CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV = 1, pix_ce is constantly 1 after reset.
- Counters (advance only on clk edges where pix_ce = 1):
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps from V_TOTAL-1 to 0.
  - Both counters are 10 bits unsigned; there is no other wrap behaviour.
- Coordinate outputs: pix_x = h_cnt, pix_y = v_cnt. Both are stable for CLK_DIV clocks.
- rgb_in handshake:
  - rgb_in must be valid at the next pix_ce edge, i.e. it may be produced through up to CLK_DIV-1 register stages clocked on clk.
  - rgb_in is sampled only on pix_ce edges.
- Output stage (registered on pix_ce edges), for the current counters:
  - {vgaRed, vgaGreen, vgaBlue} <= pix_active ? rgb_in : 12'h000.
  - Hsync <= SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~SYNC_POL.
  - Vsync <= SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~SYNC_POL.
  - Pin latency is therefore one pixel period after the coordinates; colour and sync stay mutually aligned.
- frame_tick:
  - High for exactly one clk, on the clk edge after the counters step to (h_cnt = 0, v_cnt = V_ACTIVE).
  - Occurs once per frame, i.e. every H_TOTAL*V_TOTAL*CLK_DIV clocks (1,680,000 at default parameters).
- Reset asserted mid-frame: all state returns to reset values immediately, without waiting for a clock. After release, the first pix_ce occurs CLK_DIV clocks later.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input test_en (1 bit).
  - While test_en = 1, rgb_in is ignored and the active area shows 8 vertical bars, each H_ACTIVE/8 = 80 px wide, selected by pix_x[9:0]/80.
  - Bar colours, left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Blanking, sync and latency are unchanged.
- When not defined: test_en port is absent and the colour source is always rgb_in.

Test Plan:
- Reset: hold rst_n = 0 mid-frame, then release. Outputs must be RGB = 0 with Hsync = Vsync = 1 during reset. The first pix_ce must occur on the 4th clk after release; pix_x/pix_y restart at 0,0.
- Horizontal timing: count pix_ce over one line. The line must be exactly 800 pix_ce. Hsync must be low for exactly 96 pix_ce, its first low output being the one registered at h_cnt = 656.
- Vertical timing: Vsync must be low for exactly 2 lines starting at v_cnt = 490. Frame period must be 525 lines = 1,680,000 clk.
- Blanking: hold rgb_in = 12'hFFF. Pins must be F/F/F only for the 640x480 active pixels and 0 for every other pixel; pin colour must lag the coordinates by one pixel period.
- frame_tick: over 3 frames, expect exactly 3 single-clk pulses, each 1,680,000 clk apart, coinciding with pix_y = 480, pix_x = 0.
- Test pattern (VGA_TEST_PATTERN_EN, test_en = 1, rgb_in = 0): pixel x = 0 must give FFF, x = 85 must give FF0, x = 639 must give 000. With test_en = 0, the pins must follow rgb_in.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Pixel-side and VGA-pin signals of vga_sync_gen. The generator owns the master modport.
// test_en exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_sync_gen_if;
  logic [11:0] rgb_in;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_active;
  logic        pix_ce;
  logic        frame_tick;
  logic [3:0]  vgaRed;
  logic [3:0]  vgaGreen;
  logic [3:0]  vgaBlue;
  logic        Hsync;
  logic        Vsync;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_en;

  modport master (
    input  rgb_in, test_en,
    output pix_x, pix_y, pix_active, pix_ce, frame_tick,
           vgaRed, vgaGreen, vgaBlue, Hsync, Vsync
  );
  modport slave (
    output rgb_in, test_en,
    input  pix_x, pix_y, pix_active, pix_ce, frame_tick,
           vgaRed, vgaGreen, vgaBlue, Hsync, Vsync
  );
`else
  modport master (
    input  rgb_in,
    output pix_x, pix_y, pix_active, pix_ce, frame_tick,
           vgaRed, vgaGreen, vgaBlue, Hsync, Vsync
  );
  modport slave (
    output rgb_in,
    input  pix_x, pix_y, pix_active, pix_ce, frame_tick,
           vgaRed, vgaGreen, vgaBlue, Hsync, Vsync
  );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator with pixel clock-enable, blanked/registered colour and sync pins.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_TICK   = 10'(V_ACTIVE - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             tick_q, tick_d;
  logic             pix_ce;
  logic             active;
  logic [11:0]      src_rgb;

  always_comb begin
    pix_ce = (div_cnt_q == DIV_LAST);
    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [9:0]  BAR_W_C = 10'(BAR_W);
  logic [9:0] bar;

  always_comb begin
    bar     = h_cnt_q / BAR_W_C;
    src_rgb = vga.rgb_in;
    if (vga.test_en) begin
      case (bar)
        10'd0:   src_rgb = 12'hFFF;
        10'd1:   src_rgb = 12'hFF0;
        10'd2:   src_rgb = 12'h0FF;
        10'd3:   src_rgb = 12'h0F0;
        10'd4:   src_rgb = 12'hF0F;
        10'd5:   src_rgb = 12'hF00;
        10'd6:   src_rgb = 12'h00F;
        default: src_rgb = 12'h000;
      endcase
    end
  end
`else
  always_comb src_rgb = vga.rgb_in;
`endif

  // Pins are computed from the pre-step counters, so they lag pix_x/pix_y by one pixel.
  always_comb begin
    div_cnt_d = pix_ce ? '0 : div_cnt_q + 1'b1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    rgb_d     = rgb_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    tick_d    = 1'b0;
    if (pix_ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      rgb_d   = active ? src_rgb : '0;
      hsync_d = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_d = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
      tick_d  = (h_cnt_q == H_LAST) && (v_cnt_q == V_TICK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      rgb_q     <= '0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      tick_q    <= tick_d;
    end
  end

  assign vga.pix_x      = h_cnt_q;
  assign vga.pix_y      = v_cnt_q;
  assign vga.pix_active = active;
  assign vga.pix_ce     = pix_ce;
  assign vga.frame_tick = tick_q;
  assign vga.vgaRed     = rgb_q[11:8];
  assign vga.vgaGreen   = rgb_q[7:4];
  assign vga.vgaBlue    = rgb_q[3:0];
  assign vga.Hsync      = hsync_q;
  assign vga.Vsync      = vsync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a reduced 16x11 raster (CLK_DIV=4, 704 clk per frame).
module tb_vga_sync_gen;
  localparam int unsigned CD = 4;
  localparam int unsigned HA = 8;
  localparam int unsigned HF = 2;
  localparam int unsigned HS = 3;
  localparam int unsigned HB = 3;
  localparam int unsigned VA = 6;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  vga_sync_gen_if vif ();

  vga_sync_gen #(
    .CLK_DIV (CD),
    .H_ACTIVE(HA),
    .H_FP    (HF),
    .H_SYNC  (HS),
    .H_BP    (HB),
    .V_ACTIVE(VA),
    .V_FP    (VF),
    .V_SYNC  (VS),
    .V_BP    (VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vga  (vif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pins();
    return 32'({vif.vgaRed, vif.vgaGreen, vif.vgaBlue});
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  task automatic pixel_out(input int unsigned x, output logic [31:0] rgb, output logic ok);
    ok = 1'b0;
    for (int unsigned n = 0; n < 4 * HT * VT && !ok; n++) begin
      if (vif.pix_ce && 32'(vif.pix_x) == x && vif.pix_y == 10'd0) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    rgb = pins();
  endtask
`endif

  initial begin
    int unsigned mx, my, dm, hs_low, vs_low, fff_cnt, ce_cnt, first_hs, first_vs, k;
    int unsigned tick_at[$];
    logic [11:0] exp_rgb;
    logic exp_hs, exp_vs, exp_ft, ce_exp;
`ifdef VGA_TEST_PATTERN_EN
    logic [31:0] got;
    logic ok;
    vif.test_en = 1'b0;
`endif
    mx = 0; my = 0; dm = 0;
    hs_low = 0; vs_low = 0; fff_cnt = 0; ce_cnt = 0;
    first_hs = 32'hFFFF_FFFF; first_vs = 32'hFFFF_FFFF;
    exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; exp_ft = 1'b0;
    vif.rgb_in = 12'hFFF;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rgb",    pins(), 32'h000);
    chk("rst_hsync",  32'(vif.Hsync), 32'd1);
    chk("rst_vsync",  32'(vif.Vsync), 32'd1);
    chk("rst_pix_x",  32'(vif.pix_x), 32'd0);
    chk("rst_pix_y",  32'(vif.pix_y), 32'd0);
    chk("rst_pix_ce", 32'(vif.pix_ce), 32'd0);
    chk("rst_tick",   32'(vif.frame_tick), 32'd0);
    chk("rst_active", 32'(vif.pix_active), 32'd1);

    // Three frames against a pixel model; colour FFF in frame 0, coordinate pattern after.
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 2200; c++) begin
      vif.rgb_in = (c < 704) ? 12'hFFF : {mx[3:0], my[3:0], 4'hA};
      ce_exp = (dm == CD - 1);
      chk("pix_ce",     32'(vif.pix_ce), 32'(ce_exp));
      chk("pix_x",      32'(vif.pix_x), mx);
      chk("pix_y",      32'(vif.pix_y), my);
      chk("pix_active", 32'(vif.pix_active), 32'(mx < HA && my < VA));
      chk("rgb_pins",   pins(), 32'(exp_rgb));
      chk("hsync",      32'(vif.Hsync), 32'(exp_hs));
      chk("vsync",      32'(vif.Vsync), 32'(exp_vs));
      chk("frame_tick", 32'(vif.frame_tick), 32'(exp_ft));
      if (c < 64) begin
        if (!vif.Hsync) hs_low++;
        if (vif.pix_ce) ce_cnt++;
      end
      if (c < 704) begin
        if (!vif.Vsync) vs_low++;
        if (pins() == 32'hFFF) fff_cnt++;
      end
      if (!vif.Hsync && first_hs == 32'hFFFF_FFFF) first_hs = c;
      if (!vif.Vsync && first_vs == 32'hFFFF_FFFF) first_vs = c;
      if (vif.frame_tick) begin
        tick_at.push_back(c);
        chk("tick_pos", 32'({vif.pix_y, vif.pix_x}), 32'({10'd6, 10'd0}));
      end
      exp_ft = 1'b0;
      if (ce_exp) begin
        exp_rgb = (mx < HA && my < VA) ? vif.rgb_in : 12'h000;
        exp_hs  = !(mx >= HA + HF && mx < HA + HF + HS);
        exp_vs  = !(my >= VA + VF && my < VA + VF + VS);
        exp_ft  = (mx == HT - 1 && my == VA - 1);
        if (mx == HT - 1) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
      dm = (dm == CD - 1) ? 0 : dm + 1;
      @(posedge clk);
      @(negedge clk);
    end

    chk("ce_per_line",    ce_cnt, 32'd16);
    chk("hs_low_clks",    hs_low, 32'd12);
    chk("first_hs_low",   first_hs, 32'd44);
    chk("vs_low_clks",    vs_low, 32'd128);
    chk("first_vs_low",   first_vs, 32'd452);
    chk("fff_clks",       fff_cnt, 32'd192);
    chk("tick_count",     32'(tick_at.size()), 32'd3);
    if (tick_at.size() == 3) begin
      chk("tick0_cycle", tick_at[0], 32'd384);
      chk("tick_gap1",   tick_at[1] - tick_at[0], 32'd704);
      chk("tick_gap2",   tick_at[2] - tick_at[1], 32'd704);
    end

    // Asynchronous reset mid-frame, checked before any clock edge
    chk("pre_rst_rgb", pins(), 32'h51A);
    chk("pre_rst_x",   32'(vif.pix_x), 32'd6);
    chk("pre_rst_y",   32'(vif.pix_y), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb",   pins(), 32'h000);
    chk("arst_hsync", 32'(vif.Hsync), 32'd1);
    chk("arst_vsync", 32'(vif.Vsync), 32'd1);
    chk("arst_x",     32'(vif.pix_x), 32'd0);
    chk("arst_y",     32'(vif.pix_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!vif.pix_ce && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("first_ce_edge", k + 1, 32'd4);
    chk("restart_x", 32'(vif.pix_x), 32'd0);
    chk("restart_y", 32'(vif.pix_y), 32'd0);

`ifdef VGA_TEST_PATTERN_EN
    vif.test_en = 1'b1;
    vif.rgb_in  = 12'h000;
    pixel_out(0, got, ok);
    chk("tp_wait0", 32'(ok), 32'd1);
    chk("tp_x0", got, 32'hFFF);
    pixel_out(1, got, ok);
    chk("tp_wait1", 32'(ok), 32'd1);
    chk("tp_x1", got, 32'hFF0);
    pixel_out(5, got, ok);
    chk("tp_wait5", 32'(ok), 32'd1);
    chk("tp_x5", got, 32'hF00);
    pixel_out(7, got, ok);
    chk("tp_wait7", 32'(ok), 32'd1);
    chk("tp_x7", got, 32'h000);
    pixel_out(9, got, ok);
    chk("tp_wait9", 32'(ok), 32'd1);
    chk("tp_blank", got, 32'h000);
    vif.test_en = 1'b0;
    vif.rgb_in  = 12'h5A3;
    pixel_out(2, got, ok);
    chk("tp_off_wait", 32'(ok), 32'd1);
    chk("tp_off_rgb", got, 32'h5A3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
